// File: rtl/stopwatch_ctrl.sv
// Stopwatch command sequencer: button sync/debounce, IDLE/RUN/PAUSE/STOP FSM, 0.1 s tick.
// Latency: button rise to press pulse 2+DEB_CYCLES cycles; state changes on the next edge.
// Backpressure: none; presses and wrap are acted on (or dropped) in the cycle they occur.
//
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   enable                            master run switch (level); low forces IDLE and clear
//   btn_reset/count/pause/stop        raw active-high push-buttons, asynchronous to clk
//   wrap                              datapath pulse: tick consumed at 999.9
//   tick                              one-cycle pulse every TICK_DIV cycles while count_en
//   count_en, disp_en                 Moore-decoded datapath / display enables
//   clear                             one-cycle (or held while enable low) digit clear
//   state                             current FSM state code
module stopwatch_ctrl #(
  parameter int DEB_CYCLES = 500000,
  parameter int TICK_DIV   = 5000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       btn_reset,
  input  logic       btn_count,
  input  logic       btn_pause,
  input  logic       btn_stop,
  input  logic       wrap,
  output logic       tick,
  output logic       count_en,
  output logic       clear,
  output logic       disp_en,
  output logic [2:0] state
);

  localparam int NBTN = 4;
  localparam int CW   = $clog2(DEB_CYCLES + 1);
  localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [CW-1:0] DEB_MAX  = CW'(DEB_CYCLES);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  localparam logic [2:0] S_IDLE  = 3'b000;
  localparam logic [2:0] S_RUN   = 3'b010;
  localparam logic [2:0] S_PAUSE = 3'b011;
  localparam logic [2:0] S_STOP  = 3'b100;

  // Button index map: 0 count, 1 pause, 2 stop, 3 reset.
  logic [NBTN-1:0] btn_raw;
  logic [NBTN-1:0] sync1;
  logic [NBTN-1:0] sync2;
  logic [NBTN-1:0] press;
  logic [CW-1:0]   deb_cnt [NBTN];

  logic [PW-1:0]   presc;
  logic [2:0]      state_nxt;
  logic            clear_nxt;
  logic            run_like;
  logic            legal;

  assign btn_raw = {btn_reset, btn_stop, btn_pause, btn_count};

  // Debounce: the counter saturates at DEB_CYCLES, so the press pulse fires only on the
  // sample where it steps from DEB_CYCLES-1 to DEB_CYCLES. A single low sample rearms it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      press <= '0;
      for (int i = 0; i < NBTN; i++) deb_cnt[i] <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      for (int i = 0; i < NBTN; i++) begin
        press[i] <= sync2[i] && (deb_cnt[i] == DEB_LAST);
        if (!sync2[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] != DEB_MAX) begin
          deb_cnt[i] <= deb_cnt[i] + CW'(1);
        end
      end
    end
  end

  assign run_like = (state == S_RUN) || (state == S_PAUSE);
  assign legal    = run_like || (state == S_IDLE) || (state == S_STOP);

  // Priority chain: enable low, then wrap, then reset > stop > pause > count.
  // Only the highest-priority press acts; if it is meaningless in the current
  // state the lower presses of the same cycle are still dropped.
  always_comb begin
    state_nxt = state;
    clear_nxt = 1'b0;
    if (!enable) begin
      state_nxt = S_IDLE;
      clear_nxt = 1'b1;
    end else if (!legal) begin
      state_nxt = S_IDLE;
    end else if (wrap && run_like) begin
      state_nxt = S_IDLE;
      clear_nxt = 1'b1;
    end else if (press[3]) begin
      state_nxt = S_IDLE;
      clear_nxt = 1'b1;
    end else if (press[2]) begin
      if (run_like) state_nxt = S_STOP;
    end else if (press[1]) begin
      if (state == S_RUN) state_nxt = S_PAUSE;
    end else if (press[0]) begin
      if (state != S_RUN) state_nxt = S_RUN;
    end
  end

  // clear is registered alongside the state so it lands in the first IDLE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      clear <= 1'b0;
    end else begin
      state <= state_nxt;
      clear <= clear_nxt;
    end
  end

  // Prescaler is zeroed on the same edge that raises clear, so it already reads 0
  // during the clear cycle. It holds (not clears) outside RUN/PAUSE, keeping the
  // partial tenth across STOP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (clear_nxt) begin
      presc <= '0;
    end else if (count_en) begin
      presc <= (presc == PRE_LAST) ? '0 : presc + PW'(1);
    end
  end

  assign count_en = run_like;
  assign disp_en  = (state == S_IDLE) || (state == S_RUN);
  assign tick     = count_en && (presc == PRE_LAST);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
module tb_stopwatch_ctrl;

  localparam int DEB  = 4;
  localparam int TDIV = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       btn_reset;
  logic       btn_count;
  logic       btn_pause;
  logic       btn_stop;
  logic       wrap;
  logic       tick;
  logic       count_en;
  logic       clear;
  logic       disp_en;
  logic [2:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.DEB_CYCLES(DEB), .TICK_DIV(TDIV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .btn_reset (btn_reset),
    .btn_count (btn_count),
    .btn_pause (btn_pause),
    .btn_stop  (btn_stop),
    .wrap      (wrap),
    .tick      (tick),
    .count_en  (count_en),
    .clear     (clear),
    .disp_en   (disp_en),
    .state     (state)
  );

  // Advance n clock edges; sample/drive 1 ns after the edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Hold the selected buttons {reset,stop,pause,count} for 6 cycles (press pulse
  // visible after the 6th edge), release, and take the edge that applies the press.
  task automatic press_btns(input logic [3:0] b);
    {btn_reset, btn_stop, btn_pause, btn_count} = b;
    step(6);
    {btn_reset, btn_stop, btn_pause, btn_count} = 4'b0000;
    step(1);
  endtask

  // Number of cycles until tick is seen, counting the current cycle as 1.
  // Returns 0 if no tick within 40 cycles. Leaves time in the tick cycle.
  task automatic cycles_to_tick(output int n);
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      if (tick === 1'b1) begin
        n = k;
        return;
      end
      step(1);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; enable = 1'b1; wrap = 1'b0;
    btn_reset = 1'b0; btn_count = 1'b0; btn_pause = 1'b0; btn_stop = 1'b0;
    #2;
    n_checks++;
    if ({state, tick, count_en, clear, disp_en} !== 7'b000_0001) begin
      n_fail++;
      $display("FAIL reset_outputs: {state,tick,count_en,clear,disp_en}=%b expected=%b",
               {state, tick, count_en, clear, disp_en}, 7'b000_0001);
    end
    step(3);
    rst_n = 1'b1;
    step(2);
    n_checks++;
    if ({state, clear} !== 4'b000_0) begin
      n_fail++;
      $display("FAIL reset_release: {state,clear}=%b expected=0000", {state, clear});
    end
  endtask

  task automatic test_glitch;
    btn_count = 1'b1; step(3);
    btn_count = 1'b0; step(1);
    btn_count = 1'b1; step(3);
    btn_count = 1'b0; step(6);
    n_checks++;
    if (state !== 3'b000) begin
      n_fail++;
      $display("FAIL glitch_rejected: state=%b expected=000", state);
    end
  endtask

  task automatic test_count_start;
    int n;
    btn_count = 1'b1;
    step(6);
    n_checks++;
    if (state !== 3'b000) begin
      n_fail++;
      $display("FAIL count_press_cycle6: state=%b expected=000", state);
    end
    btn_count = 1'b0;
    step(1);
    n_checks++;
    if ({state, count_en, disp_en} !== 5'b010_11) begin
      n_fail++;
      $display("FAIL run_entry: {state,count_en,disp_en}=%b expected=01011",
               {state, count_en, disp_en});
    end
    cycles_to_tick(n);
    n_checks++;
    if (n != 10) begin
      n_fail++;
      $display("FAIL first_tick: cycles=%0d expected=10", n);
    end
  endtask

  task automatic test_pause;
    int n;
    press_btns(4'b0010);
    n_checks++;
    if ({state, count_en, disp_en} !== 5'b011_10) begin
      n_fail++;
      $display("FAIL pause_entry: {state,count_en,disp_en}=%b expected=01110",
               {state, count_en, disp_en});
    end
    cycles_to_tick(n);
    step(1);
    cycles_to_tick(n);
    n_checks++;
    if (n != 10) begin
      n_fail++;
      $display("FAIL pause_tick_period: cycles=%0d expected=10", n);
    end
    // Pause in PAUSE is ignored.
    press_btns(4'b0010);
    n_checks++;
    if (state !== 3'b011) begin
      n_fail++;
      $display("FAIL pause_in_pause: state=%b expected=011", state);
    end
    press_btns(4'b0001);
    n_checks++;
    if ({state, disp_en} !== 4'b010_1) begin
      n_fail++;
      $display("FAIL resume_from_pause: {state,disp_en}=%b expected=0101", {state, disp_en});
    end
  endtask

  task automatic test_stop_resume;
    int n;
    int ticks;
    cycles_to_tick(n);
    step(1);                  // prescaler now 0
    press_btns(4'b0100);      // press lands while prescaler is 6
    n_checks++;
    if ({state, count_en, disp_en} !== 5'b100_00) begin
      n_fail++;
      $display("FAIL stop_entry: {state,count_en,disp_en}=%b expected=10000",
               {state, count_en, disp_en});
    end
    ticks = 0;
    for (int k = 0; k < 12; k++) begin
      if (tick === 1'b1) ticks++;
      step(1);
    end
    n_checks++;
    if (ticks != 0) begin
      n_fail++;
      $display("FAIL stop_no_tick: ticks=%0d expected=0", ticks);
    end
    press_btns(4'b0001);
    n_checks++;
    if (state !== 3'b010) begin
      n_fail++;
      $display("FAIL resume_from_stop: state=%b expected=010", state);
    end
    cycles_to_tick(n);
    n_checks++;
    if (n != 3) begin
      n_fail++;
      $display("FAIL partial_tenth_kept: cycles=%0d expected=3", n);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    press_btns(4'b1100);      // reset and stop coincide
    n_checks++;
    if ({state, clear, tick, disp_en} !== 6'b000_101) begin
      n_fail++;
      $display("FAIL reset_beats_stop: {state,clear,tick,disp_en}=%b expected=000101",
               {state, clear, tick, disp_en});
    end
    step(1);
    n_checks++;
    if (clear !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_one_cycle: clear=%b expected=0", clear);
    end
    press_btns(4'b0001);
    cycles_to_tick(n);
    n_checks++;
    if (n != 10) begin
      n_fail++;
      $display("FAIL prescaler_zeroed: cycles=%0d expected=10", n);
    end
  endtask

  task automatic test_wrap_enable;
    wrap = 1'b1;
    step(1);
    wrap = 1'b0;
    n_checks++;
    if ({state, clear} !== 4'b000_1) begin
      n_fail++;
      $display("FAIL wrap_clear: {state,clear}=%b expected=0001", {state, clear});
    end
    step(1);
    n_checks++;
    if (clear !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_clear_drop: clear=%b expected=0", clear);
    end
    press_btns(4'b0001);
    press_btns(4'b0010);
    n_checks++;
    if (state !== 3'b011) begin
      n_fail++;
      $display("FAIL reach_pause: state=%b expected=011", state);
    end
    enable = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step(1);
      n_checks++;
      if ({state, clear} !== 4'b000_1) begin
        n_fail++;
        $display("FAIL enable_low_hold[%0d]: {state,clear}=%b expected=0001", k, {state, clear});
      end
    end
    press_btns(4'b0001);      // count press ignored while enable low
    n_checks++;
    if ({state, clear} !== 4'b000_1) begin
      n_fail++;
      $display("FAIL enable_overrides: {state,clear}=%b expected=0001", {state, clear});
    end
    enable = 1'b1;
    step(1);
    n_checks++;
    if ({state, clear, disp_en} !== 5'b000_01) begin
      n_fail++;
      $display("FAIL enable_release: {state,clear,disp_en}=%b expected=00001",
               {state, clear, disp_en});
    end
  endtask

  task automatic test_async_reset;
    press_btns(4'b0001);
    step(3);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({state, tick, count_en, clear, disp_en} !== 7'b000_0001) begin
      n_fail++;
      $display("FAIL async_reset: {state,tick,count_en,clear,disp_en}=%b expected=%b",
               {state, tick, count_en, clear, disp_en}, 7'b000_0001);
    end
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_count_start();
    test_pause();
    test_stop_resume();
    test_back_to_back();
    test_wrap_enable();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
